// File: rtl/phase_reader_if.sv
// phase_reader_if: oscillator taps, measurement request and result bundle for phase_reader.
interface phase_reader_if #(parameter int WIN_W = 16);
    logic             osc_a;
    logic             osc_b;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic [WIN_W-1:0] mismatch_count;
    logic             anti_phase;
    modport master (
        output osc_a, osc_b, start, window_len,
        input  busy, done, result_valid, mismatch_count, anti_phase
    );
    modport slave (
        input  osc_a, osc_b, start, window_len,
        output busy, done, result_valid, mismatch_count, anti_phase
    );
endinterface

// File: rtl/phase_reader.sv
// phase_reader: counts cycles where two synchronised oscillator taps disagree over a
// programmable window and reports in-phase (0) / anti-phase (1).
module phase_reader #(
    parameter int SYNC_STAGES = 2,
    parameter int WIN_W       = 16
) (
    input logic          clk,
    input logic          rstn,
    phase_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
    logic [WIN_W-1:0]       r_win, r_tick, r_cnt, w_cnt_next;
    logic                   r_valid, r_anti, w_accept, w_mis;
    assign w_mis      = r_sync_a[SYNC_STAGES-1] ^ r_sync_b[SYNC_STAGES-1];
    assign w_accept   = (r_state == IDLE) && bus.start;
    // only samples taken in MEASURE may contribute, including the final one feeding anti_phase
    assign w_cnt_next = r_cnt + WIN_W'(w_mis && (r_state == MEASURE));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = SETTLE;
            SETTLE:  if (r_tick == WIN_W'(SYNC_STAGES - 1)) w_next = (r_win == '0) ? DONE : MEASURE;
            MEASURE: if (r_tick + WIN_W'(1) == r_win) w_next = DONE;
            DONE:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_win    <= '0;
            r_tick   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_anti   <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], bus.osc_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.osc_b};
            if (w_accept) begin
                r_win   <= bus.window_len;
                r_tick  <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else if (r_state == SETTLE) begin
                r_tick <= (w_next == SETTLE) ? r_tick + WIN_W'(1) : '0;
            end else if (r_state == MEASURE) begin
                r_tick <= r_tick + WIN_W'(1);
                r_cnt  <= w_cnt_next;
            end
            if (w_next == DONE) begin
                r_valid <= 1'b1;
                r_anti  <= w_cnt_next > (r_win >> 1);
            end
        end
    end
    assign bus.busy           = (r_state == SETTLE) || (r_state == MEASURE);
    assign bus.done           = (r_state == DONE);
    assign bus.result_valid   = r_valid;
    assign bus.mismatch_count = r_cnt;
    assign bus.anti_phase     = r_anti;
endmodule

// File: tb/tb_phase_reader.sv
// tb_phase_reader: table, random and corner-case checks of phase_reader against a
// delayed-tap mismatch model.
module tb_phase_reader;
    localparam int S = 2;
    localparam int W = 16;
    localparam int HN = 8192;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   mode = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   hist [HN];
    phase_reader_if #(.WIN_W(W)) bus ();
    phase_reader #(.SYNC_STAGES(S), .WIN_W(W)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    typedef struct {
        int mode;
        int win;
        int exp_cnt;
        bit exp_anti;
    } vec_t;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // raw tap generator; hist records the raw disagreement seen in each cycle
    initial begin
        bit a, b;
        forever begin
            @(negedge clk);
            case (mode)
                0: begin a = ((cyc / 5) % 2) == 1; b = a; end
                1: begin a = ((cyc / 5) % 2) == 1; b = ~a; end
                2: begin a = (cyc % 8) < 4; b = ((cyc + 6) % 8) < 4; end
                default: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
            endcase
            bus.osc_a = a;
            bus.osc_b = b;
            hist[cyc % HN] = a ^ b;
        end
    end
    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    // after the synchronisers, a start driven in cycle k samples raw cycles k+1..k+win
    function automatic int model_count(input int k, input int win);
        int s = 0;
        for (int i = k + 1; i <= k + win; i++) s += int'(hist[i % HN]);
        return s;
    endfunction
    task automatic do_start(input int win, output int k);
        @(negedge clk);
        bus.window_len = W'(win);
        bus.start = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("valid_cleared_by_start", bus.result_valid, 0);
    endtask
    task automatic wait_done(input string nm, input int k, input int win, input bit use_model,
                             input int exp_cnt_in, input bit exp_anti_in, input bit poke_start);
        bit seen = 1'b0;
        int exp_cnt = exp_cnt_in;
        bit exp_anti = exp_anti_in;
        for (int i = 0; i < win + S + 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({nm, "_done_seen"}, seen, 1);
        if (!seen) return;
        if (use_model) begin
            exp_cnt = model_count(k, win);
            exp_anti = exp_cnt > win / 2;
        end
        check({nm, "_latency"}, cyc - k, 1 + S + win);
        check({nm, "_count"}, bus.mismatch_count, exp_cnt);
        check({nm, "_anti"}, bus.anti_phase, exp_anti);
        check({nm, "_valid"}, bus.result_valid, 1);
        check({nm, "_busy_at_done"}, bus.busy, 0);
        if (poke_start) begin
            bus.window_len = W'(7);
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({nm, "_done_one_cycle"}, bus.done, 0);
        check({nm, "_idle_after"}, bus.busy, 0);
        check({nm, "_count_held"}, bus.mismatch_count, exp_cnt);
        check({nm, "_valid_held"}, bus.result_valid, 1);
    endtask
    initial begin
        vec_t vecs [4];
        int   k;
        int   done_seen;
        vecs[0] = '{mode: 0, win: 100, exp_cnt: 0,   exp_anti: 1'b0};
        vecs[1] = '{mode: 1, win: 100, exp_cnt: 100, exp_anti: 1'b1};
        vecs[2] = '{mode: 2, win: 64,  exp_cnt: 32,  exp_anti: 1'b0};
        vecs[3] = '{mode: 1, win: 0,   exp_cnt: 0,   exp_anti: 1'b0};
        bus.start = 1'b0;
        bus.window_len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_count", bus.mismatch_count, 0);
        check("rst_anti", bus.anti_phase, 0);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            do_start(vecs[i].win, k);
            wait_done($sformatf("vec%0d", i), k, vecs[i].win, 1'b0, vecs[i].exp_cnt, vecs[i].exp_anti, 1'b0);
        end
        mode = 3;
        for (int i = 0; i < 8; i++) begin
            int w = $urandom_range(1, 60);
            do_start(w, k);
            wait_done($sformatf("rand%0d", i), k, w, 1'b1, 0, 1'b0, 1'b0);
        end
        // start while busy and start during DONE are both ignored
        mode = 1;
        do_start(100, k);
        repeat (9) @(negedge clk);
        bus.window_len = W'(7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_busy_ignored", bus.busy, 1);
        wait_done("restart", k, 100, 1'b0, 100, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("restart_still_idle", bus.busy, 0);
        check("restart_result_held", bus.mismatch_count, 100);
        // reset mid-measurement aborts without a done pulse
        do_start(100, k);
        repeat (40) @(negedge clk);
        check("pre_reset_running", bus.mismatch_count > 0, 1);
        rstn = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_valid", bus.result_valid, 0);
        check("abort_count", bus.mismatch_count, 0);
        check("abort_anti", bus.anti_phase, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            done_seen += int'(bus.done);
        end
        rstn = 1'b1;
        repeat (120) begin
            @(negedge clk);
            done_seen += int'(bus.done);
        end
        check("abort_no_done", done_seen, 0);
        do_start(20, k);
        wait_done("after_reset", k, 20, 1'b0, 20, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end
endmodule
